// File: rtl/level_interleave_stream_pkg.sv
// Shared helpers for the bit-plane re-interleaver: counter sizing, bit mapping and
// the framing-error cause codes.
package level_interleave_stream_pkg;

   typedef enum logic [1:0] {
      ERR_NONE         = 2'd0,
      ERR_EARLY_LAST   = 2'd1,
      ERR_MISSING_LAST = 2'd2
   } err_cause_e;

   function automatic int lvl_width(input int levels);
      int w;
      w = $clog2(levels);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int bit_index(input int levels, input int i, input int l);
      return levels * i + l;
   endfunction

endpackage

// File: rtl/level_interleave_stream_if.sv
// Plane-in / word-out handshake bundle for level_interleave_stream.
interface level_interleave_stream_if #(
   parameter int binary_levels = 2,
   parameter int simd_width    = 32
);
   logic [simd_width-1:0]               in_data;
   logic                                in_valid;
   logic                                in_ready;
   logic                                in_last;
   logic [simd_width*binary_levels-1:0] out_data;
   logic                                out_valid;
   logic                                out_ready;
   logic                                err;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, err
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, err
   );
endinterface

// File: rtl/level_interleave_stream_plane_interleave.sv
// Combinational map of binary_levels bit-planes into one element-interleaved word.
module plane_interleave
   import level_interleave_stream_pkg::*;
#(
   parameter int binary_levels = 2,
   parameter int simd_width    = 32
) (
   input  logic [binary_levels-1:0][simd_width-1:0] planes,
   output logic [simd_width*binary_levels-1:0]      word
);
   always_comb begin
      word = '0;
      for (int i = 0; i < simd_width; i++) begin
         for (int l = 0; l < binary_levels; l++) begin
            word[bit_index(binary_levels, i, l)] = planes[l][i];
         end
      end
   end
endmodule

// File: rtl/level_interleave_stream.sv
// Streaming bit-plane re-interleaver: collects binary_levels planes, emits one packed word.
// Optional framing check on in_last enabled by `define LEVEL_INTERLEAVE_LAST_CHECK_EN.
module level_interleave_stream
   import level_interleave_stream_pkg::*;
#(
   parameter int binary_levels = 2,
   parameter int simd_width    = 32
) (
   input logic                      clk,
   input logic                      rst,
   level_interleave_stream_if.slave bus
);
   localparam int LW = lvl_width(binary_levels);
   localparam logic [LW-1:0] LAST_LVL = LW'(binary_levels - 1);

   logic [LW-1:0]                             lvl, lvl_nxt;
   logic [binary_levels-2:0][simd_width-1:0]  acc;
   logic [binary_levels-1:0][simd_width-1:0]  planes;
   logic [simd_width*binary_levels-1:0]       word, out_data;
   logic                                      out_valid, out_valid_nxt;
   logic                                      in_ready, accept, is_final, early_last;

   assign is_final = (lvl == LAST_LVL);
   // Only the final plane needs room in the output register.
   assign in_ready = !is_final || !out_valid || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

`ifdef LEVEL_INTERLEAVE_LAST_CHECK_EN
   logic err;
   assign early_last = accept && !is_final && bus.in_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= early_last || (accept && is_final && !bus.in_last);
   end
   assign bus.err = err;
`else
   logic unused_in_last;
   assign unused_in_last = bus.in_last;
   assign early_last     = 1'b0;
   assign bus.err        = 1'b0;
`endif

   always_comb begin
      for (int k = 0; k < binary_levels - 1; k++) planes[k] = acc[k];
      planes[binary_levels-1] = bus.in_data;
   end

   plane_interleave #(
      .binary_levels(binary_levels),
      .simd_width   (simd_width)
   ) u_interleave (
      .planes(planes),
      .word  (word)
   );

   always_comb begin
      lvl_nxt       = lvl;
      out_valid_nxt = out_valid;
      if (out_valid && bus.out_ready) out_valid_nxt = 1'b0;
      if (accept) begin
         if (is_final || early_last) lvl_nxt = '0;
         else                        lvl_nxt = lvl + LW'(1);
         if (is_final) out_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl       <= '0;
         out_valid <= 1'b0;
      end else begin
         lvl       <= lvl_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   // Accumulator slots are overwritten in place; never cleared between words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         out_data <= '0;
      end else if (accept) begin
         if (is_final) begin
            out_data <= word;
         end else begin
            for (int k = 0; k < binary_levels - 1; k++) begin
               if (lvl == LW'(k)) acc[k] <= bus.in_data;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
endmodule

// File: doc/level_interleave_stream.md
# level_interleave_stream

Streaming bit-plane re-interleaver for the multi-level binary datapath. It accepts one level-major bit-plane of `simd_width` bits per handshake beat. After `binary_levels` beats it emits one element-interleaved word, where output bit `binary_levels*i + l` equals bit `i` of plane `l`. It is the sequential inverse of the level-major split applied at the SIMD input. It sits between per-level compute lanes and any consumer that expects per-element packed levels.

## Interface
Parameters:
- `binary_levels`, default 2: planes per word; must be ≥ 2.
- `simd_width`, default 32: bits per plane (elements per word).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  simd_width  current bit-plane; plane `l` arrives on beat `l`.
- `in_valid`  in  1  plane present.
- `in_ready`  out  1  plane accepted when `in_valid && in_ready`.
- `in_last`  in  1  marks the final plane of a word; used only with `LEVEL_INTERLEAVE_LAST_CHECK_EN`.
- `out_data`  out  simd_width*binary_levels  interleaved word, registered.
- `out_valid`  out  1  word held in output register.
- `out_ready`  in  1  word consumed when `out_valid && out_ready`.
- `err`  out  1  one-cycle framing-error pulse; tied 0 without the macro.

## Operation
- Level counter `lvl`, range 0..binary_levels-1. Accumulator holds planes 0..binary_levels-2.
- Plane accepted at `lvl < binary_levels-1`:
  - stored into accumulator slot `lvl`;
  - `lvl` increments.
- Plane accepted at `lvl == binary_levels-1` (final beat):
  - the accumulator plus `in_data` is interleaved combinationally and loaded into `out_data`;
  - `out_valid` is set and `lvl` wraps to 0.
- Mapping: `out_data[binary_levels*i + l] = plane_l[i]`, for all i < simd_width and l < binary_levels.
- `in_ready = (lvl != binary_levels-1) || !out_valid || out_ready`. Non-final planes are never stalled by the output.
- Output handshake:
  - `out_valid` clears on `out_valid && out_ready` unless a new final beat is loaded in the same cycle, in which case it stays 1 with the new data.
  - `out_data` is stable while `out_valid && !out_ready`.
- The accumulator is not cleared between words. It is overwritten slot by slot.

## Timing
- Reset (asynchronous, while `rst` = 1): `lvl` = 0, `out_valid` = 0, `out_data` = 0, accumulator = 0, `err` = 0. `in_ready` = 1 after reset.
- Latency: `out_valid` rises the cycle after the final-plane acceptance.
- Throughput: one plane per cycle sustained when `out_ready` = 1, so one word per `binary_levels` cycles with no bubbles.
- Simultaneous output drain and final-plane load in one cycle: both take effect and no word is dropped.
- Reset asserted mid-word: the partial word is discarded and any held output word is lost.
- `in_valid` low: no state change; gaps between planes of a word are permitted.

## Configuration
`LEVEL_INTERLEAVE_LAST_CHECK_EN`:
- Defined:
  - `in_last` is sampled on every accepted beat.
  - `in_last` = 1 at `lvl != binary_levels-1` (early last): `err` pulses, `lvl` resets to 0, the partial word is discarded and no output is produced.
  - `in_last` = 0 at `lvl == binary_levels-1` (missing last): `err` pulses, but the word is still emitted normally.
- Not defined: `in_last` is ignored, `err` = 0 constantly, and no check logic is synthesized.

## Structure
Shared package:
- function returning the counter width, clog2(binary_levels) with a minimum of 1;
- bit-index function `binary_levels*i + l`;
- error-cause encoding constants, used by the bench.

Sub-module `plane_interleave`: purely combinational. It maps `binary_levels` planes to one interleaved word and is instantiated once on the final-beat path. The FSM, accumulator and output register live in the top.

## Test plan
- **Basic word:** binary_levels=2, simd_width=4, `out_ready`=1. Send planes 4'b1010 then 4'b0110 → `out_data` = 8'h6C with `out_valid` one cycle after beat 2.
- **Back-to-back streaming:** 8 words, `in_valid` held high → one plane accepted every cycle, `in_ready` never drops, and each word matches the reference model.
- **Backpressure:** `out_ready`=0 with one word held and the next word filling → `in_ready` drops only at lvl=1. Raise `out_ready` → the held word drains and the new word loads in the same cycle, with no loss.
- **Reset mid-word:** accept plane 0, then pulse `rst` → outputs are zero, and the next two planes form a correct word.
- **Framing (macro on):** assert `in_last` on plane 0 → `err` = 1 for one cycle and no output. The following two correctly framed planes → a correct word with `err` = 0.
- **Parameter sweep:** binary_levels=3, simd_width=32, random planes → round-trip against the level-major split function gives identity.
